flght_cntrl_pd: RTL and testbench

FLGHT_CNTRL_PD -- requirements
Module: flght_cntrl_pd

---
 rtl/flght_pkg.sv | 39 +++
 rtl/pd_axis.sv | 67 ++++++
 rtl/flght_cntrl_pd.sv | 203 ++++++++++++++++++++
 tb/tb_flght_cntrl_pd.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/flght_pkg.sv
// Shared constants, FSM state type and saturation helpers for the PD flight controller.
package flght_pkg;

  // Motor speed commanded while the inertial sensor calibrates.
  localparam logic [10:0] CAL_SPEED     = 11'h290;
  // Offset added to thrust so that spinning motors never stall.
  localparam logic [12:0] MIN_RUN_SPEED = 13'h02C0;
  // Gain applied to the saturated derivative difference.
  localparam int          D_COEFF       = 7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCal  = 2'd1,
    StRun  = 2'd2
  } state_e;

  // Clamp a wide signed value into the 10-bit signed error range.
  function automatic logic signed [9:0] sat10(input logic signed [32:0] v);
    if (v > 33'sd511) begin
      return 10'sd511;
    end else if (v < -33'sd512) begin
      return -10'sd512;
    end else begin
      return v[9:0];
    end
  endfunction

  // Clamp an 11-bit signed difference into the 7-bit signed derivative range.
  function automatic logic signed [6:0] sat7(input logic signed [10:0] v);
    if (v > 11'sd63) begin
      return 7'sd63;
    end else if (v < -11'sd64) begin
      return -7'sd64;
    end else begin
      return v[6:0];
    end
  endfunction

endpackage

// File: rtl/pd_axis.sv
// One control axis: saturated error, proportional term, and a derivative term taken
// against the oldest sample of a D_DEPTH-deep history queue.
module pd_axis
  import flght_pkg::*;
#(
  parameter int unsigned ANG_W   = 16,
  parameter int unsigned D_DEPTH = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vld_i,
  input  logic                    flush_i,
  input  logic signed [ANG_W-1:0] des_i,
  input  logic signed [ANG_W-1:0] act_i,
  output logic signed [9:0]       pterm_o,
  output logic signed [11:0]      dterm_o
);

  localparam int unsigned CntW    = $clog2(D_DEPTH + 1);
  localparam logic [CntW-1:0] FillMax = CntW'(D_DEPTH);
  localparam logic signed [11:0] DCoeff = 12'(D_COEFF);

  logic signed [9:0]  queue_q [D_DEPTH];
  logic [CntW-1:0]    fill_q;

  logic signed [32:0] act_x;
  logic signed [32:0] des_x;
  logic signed [32:0] diff;
  logic signed [9:0]  err;
  logic signed [10:0] d_diff;
  logic signed [6:0]  d_sat;
  logic signed [11:0] d_ext;
  logic signed [11:0] d_prod;

  // Error, P and D terms; D stays zero until the history queue holds real samples.
  always_comb begin
    act_x   = 33'(act_i);
    des_x   = 33'(des_i);
    diff    = act_x - des_x;
    err     = sat10(diff);
    pterm_o = (err >>> 1) + (err >>> 3);
    d_diff  = {err[9], err} - {queue_q[D_DEPTH-1][9], queue_q[D_DEPTH-1]};
    d_sat   = sat7(d_diff);
    d_ext   = 12'(d_sat);
    d_prod  = d_ext * DCoeff;
    dterm_o = (fill_q == FillMax) ? d_prod : '0;
  end

  // History shift register and saturating fill counter, cleared on reset or RUN entry.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      for (int i = 0; i < int'(D_DEPTH); i++) begin
        queue_q[i] <= '0;
      end
      fill_q <= '0;
    end else if (vld_i) begin
      queue_q[0] <= err;
      for (int i = 1; i < int'(D_DEPTH); i++) begin
        queue_q[i] <= queue_q[i-1];
      end
      if (fill_q != FillMax) begin
        fill_q <= fill_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/flght_cntrl_pd.sv
// Quadcopter PD attitude controller: three pd_axis instances, motor mixer and mode FSM.
// Optional build macro FLGHT_SLEW_EN limits the per-sample speed change to SLEW in RUN.
module flght_cntrl_pd
  import flght_pkg::*;
#(
  parameter int unsigned ANG_W   = 16,
  parameter int unsigned SPD_W   = 11,
  parameter int unsigned D_DEPTH = 12,
  parameter int unsigned SLEW    = 'h040
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vld,
  input  logic                    inertial_cal,
  input  logic signed [ANG_W-1:0] d_ptch,
  input  logic signed [ANG_W-1:0] d_roll,
  input  logic signed [ANG_W-1:0] d_yaw,
  input  logic signed [ANG_W-1:0] ptch,
  input  logic signed [ANG_W-1:0] roll,
  input  logic signed [ANG_W-1:0] yaw,
  input  logic [8:0]              thrst,
  output logic [SPD_W-1:0]        frnt_spd,
  output logic [SPD_W-1:0]        bck_spd,
  output logic [SPD_W-1:0]        lft_spd,
  output logic [SPD_W-1:0]        rght_spd,
  output logic [1:0]              state
);

  localparam int unsigned      MixW   = SPD_W + 2;
  localparam logic [SPD_W-1:0] SpdMax = '1;
  localparam logic [SPD_W-1:0] SpdCal = SPD_W'(CAL_SPEED);

  state_e state_q, state_d;
  logic   flush;

  logic signed [9:0]  pterm_p, pterm_r, pterm_y;
  logic signed [11:0] dterm_p, dterm_r, dterm_y;

  logic signed [MixW-1:0] base, pp, dp, pr, dr, py, dy;
  logic signed [MixW-1:0] mix [4];
  logic [SPD_W-1:0]       tgt [4];
  logic [SPD_W-1:0]       nxt [4];
  logic [SPD_W-1:0]       spd_q [4];

  pd_axis #(
    .ANG_W   (ANG_W),
    .D_DEPTH (D_DEPTH)
  ) u_axis_ptch (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld_i   (vld),
    .flush_i (flush),
    .des_i   (d_ptch),
    .act_i   (ptch),
    .pterm_o (pterm_p),
    .dterm_o (dterm_p)
  );

  pd_axis #(
    .ANG_W   (ANG_W),
    .D_DEPTH (D_DEPTH)
  ) u_axis_roll (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld_i   (vld),
    .flush_i (flush),
    .des_i   (d_roll),
    .act_i   (roll),
    .pterm_o (pterm_r),
    .dterm_o (dterm_r)
  );

  pd_axis #(
    .ANG_W   (ANG_W),
    .D_DEPTH (D_DEPTH)
  ) u_axis_yaw (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld_i   (vld),
    .flush_i (flush),
    .des_i   (d_yaw),
    .act_i   (yaw),
    .pterm_o (pterm_y),
    .dterm_o (dterm_y)
  );

  // Motor mixer with clamping into the unsigned speed range (no wrap-around).
  always_comb begin
    base   = MixW'(thrst) + MixW'(MIN_RUN_SPEED);
    pp     = MixW'(pterm_p);
    dp     = MixW'(dterm_p);
    pr     = MixW'(pterm_r);
    dr     = MixW'(dterm_r);
    py     = MixW'(pterm_y);
    dy     = MixW'(dterm_y);
    mix[0] = base - pp - dp - py - dy;
    mix[1] = base + pp + dp - py - dy;
    mix[2] = base - pr - dr + py + dy;
    mix[3] = base + pr + dr + py + dy;
    for (int k = 0; k < 4; k++) begin
      if (mix[k][MixW-1]) begin
        tgt[k] = '0;
      end else if (mix[k][SPD_W]) begin
        tgt[k] = SpdMax;
      end else begin
        tgt[k] = mix[k][SPD_W-1:0];
      end
    end
  end

`ifdef FLGHT_SLEW_EN
  localparam logic [SPD_W-1:0] SlewV = SPD_W'(SLEW);

  // Step each motor toward its target by at most SlewV per sample.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      if (tgt[k] > spd_q[k]) begin
        nxt[k] = ((tgt[k] - spd_q[k]) > SlewV) ? spd_q[k] + SlewV : tgt[k];
      end else begin
        nxt[k] = ((spd_q[k] - tgt[k]) > SlewV) ? spd_q[k] - SlewV : tgt[k];
      end
    end
  end
`else
  logic [SPD_W-1:0] unused_slew;
  assign unused_slew = SPD_W'(SLEW);

  // Without slew limiting the target is loaded directly.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      nxt[k] = tgt[k];
    end
  end
`endif

  // Mode transitions; calibration wins over thrust in IDLE and RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (inertial_cal) begin
          state_d = StCal;
        end else if (thrst != '0) begin
          state_d = StRun;
        end
      end
      StCal: begin
        if (!inertial_cal) begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (inertial_cal) begin
          state_d = StCal;
        end else if (vld && (thrst == '0)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // D-history restarts whenever RUN is entered.
  assign flush = (state_d == StRun) && (state_q != StRun);

  // State register and registered speeds; IDLE/CAL speeds apply on the entering edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      for (int k = 0; k < 4; k++) begin
        spd_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      unique case (state_d)
        StCal: begin
          for (int k = 0; k < 4; k++) begin
            spd_q[k] <= SpdCal;
          end
        end
        StRun: begin
          if (vld && (state_q == StRun)) begin
            for (int k = 0; k < 4; k++) begin
              spd_q[k] <= nxt[k];
            end
          end
        end
        default: begin
          for (int k = 0; k < 4; k++) begin
            spd_q[k] <= '0;
          end
        end
      endcase
    end
  end

  assign frnt_spd = spd_q[0];
  assign bck_spd  = spd_q[1];
  assign lft_spd  = spd_q[2];
  assign rght_spd = spd_q[3];
  assign state    = state_q;

endmodule

// File: tb/tb_flght_cntrl_pd.sv
// Directed bench for flght_cntrl_pd (default parameters); expectations are hand-computed
// targets, passed through a slew step model when FLGHT_SLEW_EN is defined.
module tb_flght_cntrl_pd;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               vld;
  logic               inertial_cal;
  logic signed [15:0] d_ptch, d_roll, d_yaw, ptch, roll, yaw;
  logic [8:0]         thrst;
  logic [10:0]        frnt_spd, bck_spd, lft_spd, rght_spd;
  logic [1:0]         state;

  int n_assert = 0;
  int n_fail   = 0;

  logic [10:0] req_spd [4];
  logic [10:0] spd [4];

  assign spd[0] = frnt_spd;
  assign spd[1] = bck_spd;
  assign spd[2] = lft_spd;
  assign spd[3] = rght_spd;

  always #5 clk = ~clk;

  flght_cntrl_pd dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vld          (vld),
    .inertial_cal (inertial_cal),
    .d_ptch       (d_ptch),
    .d_roll       (d_roll),
    .d_yaw        (d_yaw),
    .ptch         (ptch),
    .roll         (roll),
    .yaw          (yaw),
    .thrst        (thrst),
    .frnt_spd     (frnt_spd),
    .bck_spd      (bck_spd),
    .lft_spd      (lft_spd),
    .rght_spd     (rght_spd),
    .state        (state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] req);
    n_assert++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic chk_spd(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_spd%0d", tag, k), {5'b0, spd[k]}, {5'b0, req_spd[k]});
    end
  endtask

  task automatic set_req(input logic [10:0] v);
    for (int k = 0; k < 4; k++) begin
      req_spd[k] = v;
    end
  endtask

  function automatic logic [10:0] step(input logic [10:0] cur, input logic [10:0] tgt);
`ifdef FLGHT_SLEW_EN
    if (tgt > cur) begin
      return ((tgt - cur) > 11'h040) ? cur + 11'h040 : tgt;
    end else begin
      return ((cur - tgt) > 11'h040) ? cur - 11'h040 : tgt;
    end
`else
    return tgt;
`endif
  endfunction

  // One vld sample in RUN, then compare all motors against the stepped targets.
  task automatic pulse(input string tag, input logic [10:0] t0, input logic [10:0] t1,
                       input logic [10:0] t2, input logic [10:0] t3);
    vld = 1'b1;
    tick();
    vld = 1'b0;
    req_spd[0] = step(req_spd[0], t0);
    req_spd[1] = step(req_spd[1], t1);
    req_spd[2] = step(req_spd[2], t2);
    req_spd[3] = step(req_spd[3], t3);
    chk_spd(tag);
  endtask

  initial begin
    rst_n        = 1'b0;
    vld          = 1'b0;
    inertial_cal = 1'b0;
    thrst        = 9'd0;
    d_ptch = '0; d_roll = '0; d_yaw = '0;
    ptch   = '0; roll   = '0; yaw   = '0;
    tick();
    tick();
    chk("reset_state", {14'b0, state}, 16'd0);
    set_req(11'h000);
    chk_spd("reset");

    rst_n = 1'b1;
    tick();
    chk("idle_state", {14'b0, state}, 16'd0);
    chk_spd("idle");

    // Calibration has priority over nonzero thrust.
    inertial_cal = 1'b1;
    thrst        = 9'd100;
    tick();
    chk("cal_state", {14'b0, state}, 16'd1);
    set_req(11'h290);
    chk_spd("cal");

    inertial_cal = 1'b0;
    tick();
    chk("cal_fall_state", {14'b0, state}, 16'd0);
    set_req(11'h000);
    chk_spd("cal_fall");

    tick();
    chk("run_entry_state", {14'b0, state}, 16'd2);
    chk_spd("run_entry");

    // Zero errors: target 100 + 0x2C0 = 0x324 on every motor.
    for (int i = 1; i <= 13; i++) begin
      pulse($sformatf("ramp%0d", i), 11'h324, 11'h324, 11'h324, 11'h324);
    end
    chk("ramp_final_frnt", {5'b0, frnt_spd}, 16'h0324);
    tick();
    tick();
    chk_spd("hold");

    // Zero thrust on a vld drops back to IDLE.
    thrst = 9'd0;
    vld   = 1'b1;
    tick();
    vld   = 1'b0;
    chk("run_exit_state", {14'b0, state}, 16'd0);
    set_req(11'h000);
    chk_spd("run_exit");

    thrst = 9'd100;
    tick();
    chk("reenter_state", {14'b0, state}, 16'd2);

    for (int i = 1; i <= 11; i++) begin
      pulse($sformatf("fill%0d", i), 11'd804, 11'd804, 11'd804, 11'd804);
    end

    // Pitch error saturates to 511 -> pterm 318; dterm still blocked on the 12th vld.
    ptch = 16'sd2000;
    pulse("ptch_v12", 11'd486, 11'd1122, 11'd804, 11'd804);
`ifndef FLGHT_SLEW_EN
    chk("ptch_v12_diff", {5'b0, bck_spd - frnt_spd}, 16'd636);
`endif
    // Queue now full; oldest sample is 0 -> dterm sat7(511)*7 = 441.
    pulse("ptch_v13", 11'd45, 11'd1563, 11'd804, 11'd804);

    // Extreme yaw and roll with thrust 1: frnt clamps to 0, rght clamps to 0x7FF.
    ptch  = 16'sd0;
    yaw   = 16'sd2000;
    roll  = 16'sd2000;
    thrst = 9'd1;
    pulse("yaw_sat", 11'd0, 11'd0, 11'd705, 11'h7FF);
    tick();
    chk_spd("yaw_hold");
    chk("yaw_state", {14'b0, state}, 16'd2);

    // Reset mid-RUN takes effect on the next edge.
    rst_n = 1'b0;
    tick();
    chk("mid_reset_state", {14'b0, state}, 16'd0);
    set_req(11'h000);
    chk_spd("mid_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
